// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the N-port RAM front end.
// Byte strobes map to bit masks consumed by the RAM model.
package mem_pkg;

  localparam logic [63:0] BASE_ADDR_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  function automatic logic [63:0] strb2mask(
    input logic [7:0] s
  );
    logic [63:0] m;
    for (int k = 0; k < 8; k++) begin
      m[k*8 +: 8] = {8{s[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle: per-port request handshake plus
// the shared response bus.
interface mem_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 64
);

  logic [N_PORTS-1:0]        req_valid;
  logic [N_PORTS-1:0]        req_ready;
  logic [N_PORTS-1:0]        req_we;
  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*64-1:0]     req_wdata;
  logic [N_PORTS*8-1:0]      req_wstrb;
  logic [N_PORTS-1:0]        rsp_valid;
  logic [63:0]               rsp_rdata;
  logic                      rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_wstrb,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_wstrb,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or
// above ptr, wrapping around.
module rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [PW-1:0]      idx,
  output logic               any
);

  always_comb begin : pick
    logic [PW-1:0] p;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      p = PW'((int'(ptr) + i) % N_PORTS);
      if (!any && req[p]) begin
        any      = 1'b1;
        grant[p] = 1'b1;
        idx      = p;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port round-robin front end for a single-port word RAM.
// One transaction in flight; byte address -> 64-bit word index.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int          N_PORTS   = 2,
  parameter int          ADDR_W    = 64,
  parameter int          DATA_W    = 64,
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus,
  output logic        ram_ren,
  output logic [63:0] ram_ridx,
  input  logic [63:0] ram_rdata,
  output logic        ram_wen,
  output logic [63:0] ram_widx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  if (DATA_W != 64 || RD_LAT < 1 || RD_LAT > 4) begin : g_chk
    $error("mem_arbiter: DATA_W must be 64, RD_LAT 1..4");
  end

  state_t        state, state_n;
  logic [PW-1:0] rr_ptr, gnt_q, gidx;
  logic [N_PORTS-1:0] grant;
  logic          any;
  logic [2:0]    cnt;
  logic          we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]   wdata_q, rdata_q;
  logic [7:0]    strb_q;
  logic [63:0]   a64, idx;
  logic          below;

  rr_arbiter #(.N_PORTS(N_PORTS), .PW(PW)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign a64   = 64'(addr_q);
  assign below = a64 < BASE_ADDR;
  assign idx   = (a64 - BASE_ADDR) >> 3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_q   <= '0;
      cnt     <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (any) begin
          gnt_q   <= gidx;
          we_q    <= bus.req_we[gidx];
          addr_q  <= bus.req_addr[gidx*ADDR_W +: ADDR_W];
          wdata_q <= bus.req_wdata[gidx*64 +: 64];
          strb_q  <= bus.req_wstrb[gidx*8 +: 8];
          err_q   <= 1'b0;
        end
        ACCESS: begin
          err_q <= below;
          if (!we_q && !below) begin
            if (RD_LAT == 1) rdata_q <= ram_rdata;
            else cnt <= 3'(RD_LAT - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) rdata_q <= ram_rdata;
        end
        RESP: begin
          rr_ptr <= (gnt_q == PW'(N_PORTS - 1)) ?
                    '0 : gnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n       = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    ram_ren       = 1'b0;
    ram_ridx      = '0;
    ram_wen       = 1'b0;
    ram_widx      = '0;
    ram_wdata     = '0;
    ram_wmask     = '0;
    unique case (state)
      IDLE: begin
        // gated so nothing is readied while reset is held
        if (rst) bus.req_ready = grant;
        if (any) state_n = ACCESS;
      end
      ACCESS: begin
        state_n = RESP;
        if (below) begin
          state_n = RESP;
        end else if (!we_q) begin
          ram_ren  = 1'b1;
          ram_ridx = idx;
          if (RD_LAT != 1) state_n = WAIT;
        end else begin
          ram_wen   = |strb_q;
          ram_widx  = idx;
          ram_wdata = wdata_q;
          ram_wmask = strb2mask(strb_q);
        end
      end
      WAIT: begin
        ram_ren  = 1'b1;
        ram_ridx = idx;
        if (cnt == 3'd1) state_n = RESP;
      end
      RESP: begin
        bus.rsp_valid[gnt_q] = 1'b1;
        bus.rsp_err          = err_q;
        if (!we_q && !err_q) bus.rsp_rdata = rdata_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: RD_LAT=1 and RD_LAT=3 instances, each with
// a small word RAM model behind it.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N_PORTS(2), .ADDR_W(64)) bus1 ();
  mem_arbiter_if #(.N_PORTS(2), .ADDR_W(64)) bus3 ();

  logic        ren1, wen1, ren3, wen3;
  logic [63:0] ridx1, rdata1, widx1, wdata1, wmask1;
  logic [63:0] ridx3, rdata3, widx3, wdata3, wmask3;
  logic [63:0] mem1 [16];
  logic [63:0] mem3 [16];

  mem_arbiter #(
    .N_PORTS(2), .ADDR_W(64), .DATA_W(64),
    .BASE_ADDR(64'h8000_0000), .RD_LAT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .ram_ren(ren1), .ram_ridx(ridx1), .ram_rdata(rdata1),
    .ram_wen(wen1), .ram_widx(widx1),
    .ram_wdata(wdata1), .ram_wmask(wmask1)
  );

  mem_arbiter #(
    .N_PORTS(2), .ADDR_W(64), .DATA_W(64),
    .BASE_ADDR(64'h8000_0000), .RD_LAT(3)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3),
    .ram_ren(ren3), .ram_ridx(ridx3), .ram_rdata(rdata3),
    .ram_wen(wen3), .ram_widx(widx3),
    .ram_wdata(wdata3), .ram_wmask(wmask3)
  );

  always_comb rdata1 = mem1[ridx1[3:0]];
  always_comb rdata3 = mem3[ridx3[3:0]];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        mem1[i] <= '0;
        mem3[i] <= '0;
      end
      mem1[1] <= 64'hAAAA_BBBB_CCCC_DDDD;
      mem1[2] <= 64'hDEAD_BEEF_0123_4567;
      mem3[1] <= 64'h1234_5678_9ABC_DEF0;
      mem3[2] <= 64'h5555_6666_7777_8888;
    end else begin
      if (wen1)
        mem1[widx1[3:0]] <= (mem1[widx1[3:0]] & ~wmask1) |
                            (wdata1 & wmask1);
      if (wen3)
        mem3[widx3[3:0]] <= (mem3[widx3[3:0]] & ~wmask3) |
                            (wdata3 & wmask3);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string t, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", t, act, exp);
    end
  endtask

  task automatic zero_chk(input string t);
    chk({t, "_hs1"}, 64'({bus1.req_ready, bus1.rsp_valid,
                          bus1.rsp_err, ren1, wen1}), 64'd0);
    chk({t, "_d1"}, bus1.rsp_rdata | ridx1 | widx1 |
                    wdata1 | wmask1, 64'd0);
    chk({t, "_hs3"}, 64'({bus3.req_ready, bus3.rsp_valid,
                          bus3.rsp_err, ren3, wen3}), 64'd0);
    chk({t, "_d3"}, bus3.rsp_rdata | ridx3 | widx3 |
                    wdata3 | wmask3, 64'd0);
  endtask

  typedef struct {
    int          p;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic        ren;
    logic        wen;
    logic [63:0] idx;
    logic [63:0] mask;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  task automatic txn1(input vec_t v, input int n);
    int lat;
    string t;
    logic [1:0] oh;
    t  = $sformatf("v%0d", n);
    oh = 2'(1 << v.p);
    @(posedge clk); #1;
    bus1.req_valid            = oh;
    bus1.req_we[v.p]          = v.we;
    bus1.req_addr[v.p*64+:64] = v.addr;
    bus1.req_wdata[v.p*64+:64] = v.wdata;
    bus1.req_wstrb[v.p*8+:8]  = v.strb;
    lat = 0;
    @(negedge clk);
    while (bus1.req_ready == 2'b00 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({t, "_ready"}, 64'(bus1.req_ready), 64'(oh));
    @(posedge clk); #1;
    bus1.req_valid = '0;
    @(negedge clk);
    chk({t, "_ren"}, 64'(ren1), 64'(v.ren));
    chk({t, "_wen"}, 64'(wen1), 64'(v.wen));
    if (v.ren) chk({t, "_ridx"}, ridx1, v.idx);
    if (v.wen) begin
      chk({t, "_widx"}, widx1, v.idx);
      chk({t, "_wmask"}, wmask1, v.mask);
      chk({t, "_wdata"}, wdata1, v.wdata);
    end
    lat = 1;
    while (bus1.rsp_valid == 2'b00 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({t, "_lat"}, 64'(lat), 64'd2);
    chk({t, "_rsp"}, 64'(bus1.rsp_valid), 64'(oh));
    chk({t, "_rdata"}, bus1.rsp_rdata, v.rdata);
    chk({t, "_err"}, 64'(bus1.rsp_err), 64'(v.err));
    chk({t, "_idle"}, 64'({ren1, wen1}), 64'd0);
  endtask

  task automatic run3(input int p, input logic [63:0] addr,
                      input logic [63:0] exp, input string t);
    int lat;
    logic [1:0] oh;
    oh = 2'(1 << p);
    @(posedge clk); #1;
    bus3.req_valid          = oh;
    bus3.req_we             = '0;
    bus3.req_addr[p*64+:64] = addr;
    lat = 0;
    @(negedge clk);
    while (bus3.req_ready == 2'b00 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({t, "_ready"}, 64'(bus3.req_ready), 64'(oh));
    @(posedge clk); #1;
    bus3.req_valid = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus3.rsp_valid == 2'b00 && lat < 10);
    chk({t, "_lat"}, 64'(lat), 64'd4);
    chk({t, "_rsp"}, 64'(bus3.rsp_valid), 64'(oh));
    chk({t, "_rdata"}, bus3.rsp_rdata, exp);
  endtask

  int ngr, nrsp, lastg, expg, seen, lat;
  int pc [2];
  logic [63:0] exp_rd [2];

  initial begin
    vecs[0] = '{0, 1'b0, 64'h8000_0010, 64'h0, 8'h00,
                1'b1, 1'b0, 64'd2, 64'h0,
                64'hDEAD_BEEF_0123_4567, 1'b0};
    vecs[1] = '{1, 1'b1, 64'h8000_0008,
                64'h1111_2222_3333_4444, 8'h0F,
                1'b0, 1'b1, 64'd1, 64'h0000_0000_FFFF_FFFF,
                64'h0, 1'b0};
    vecs[2] = '{0, 1'b0, 64'h8000_0008, 64'h0, 8'h00,
                1'b1, 1'b0, 64'd1, 64'h0,
                64'hAAAA_BBBB_3333_4444, 1'b0};
    vecs[3] = '{0, 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00,
                1'b0, 1'b0, 64'd0, 64'h0, 64'h0, 1'b1};
    vecs[4] = '{1, 1'b1, 64'h8000_0018, 64'hFFFF, 8'h00,
                1'b0, 1'b0, 64'd3, 64'h0, 64'h0, 1'b0};
    vecs[5] = '{1, 1'b1, 64'h8000_001F,
                64'h0102_0304_0506_0708, 8'h81,
                1'b0, 1'b1, 64'd3, 64'hFF00_0000_0000_00FF,
                64'h0, 1'b0};
    vecs[6] = '{0, 1'b0, 64'h8000_001C, 64'h0, 8'h00,
                1'b1, 1'b0, 64'd3, 64'h0,
                64'h0100_0000_0000_0008, 1'b0};
    vecs[7] = '{1, 1'b1, 64'h0000_1000, 64'h55, 8'hFF,
                1'b0, 1'b0, 64'd0, 64'h0, 64'h0, 1'b1};
    vecs[8] = '{0, 1'b0, 64'h0, 64'h0, 8'h00,
                1'b0, 1'b0, 64'd0, 64'h0, 64'h0, 1'b1};

    bus1.req_valid = '0; bus1.req_we = '0;
    bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.req_wstrb = '0;
    bus3.req_valid = '0; bus3.req_we = '0;
    bus3.req_addr = '0; bus3.req_wdata = '0;
    bus3.req_wstrb = '0;

    #2 rst = 1'b0;
    #1 zero_chk("rst0");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 9; i++) txn1(vecs[i], i);

    // both ports held valid: grants must alternate
    exp_rd[0] = 64'hDEAD_BEEF_0123_4567;
    exp_rd[1] = 64'hAAAA_BBBB_3333_4444;
    expg  = (vecs[8].p + 1) % 2;
    ngr   = 0;
    nrsp  = 0;
    lastg = 0;
    pc[0] = 0;
    pc[1] = 0;
    @(posedge clk); #1;
    bus1.req_we = '0;
    bus1.req_addr[63:0]   = 64'h8000_0010;
    bus1.req_addr[127:64] = 64'h8000_0008;
    bus1.req_valid = 2'b11;
    for (int c = 0; c < 200 && nrsp < 20; c++) begin
      @(negedge clk);
      if (bus1.rsp_valid != 2'b00) begin
        chk("rr_rsp", 64'(bus1.rsp_valid), 64'(1 << lastg));
        chk("rr_rdata", bus1.rsp_rdata, exp_rd[lastg]);
        nrsp++;
        pc[lastg]++;
      end
      if (bus1.req_ready != 2'b00) begin
        chk("rr_gnt", 64'(bus1.req_ready), 64'(1 << expg));
        lastg = expg;
        expg  = 1 - expg;
        ngr++;
        if (ngr == 20) begin
          @(posedge clk); #1;
          bus1.req_valid = '0;
        end
      end
    end
    chk("rr_nrsp", 64'(nrsp), 64'd20);
    chk("rr_p0", 64'(pc[0]), 64'd10);
    chk("rr_p1", 64'(pc[1]), 64'd10);

    // RD_LAT=3: port1 arrives during WAIT, must not be readied
    @(posedge clk); #1;
    bus3.req_addr[63:0] = 64'h8000_0010;
    bus3.req_valid = 2'b01;
    @(negedge clk);
    chk("l3_rdy0", 64'(bus3.req_ready), 64'd1);
    @(posedge clk); #1;
    bus3.req_addr[127:64] = 64'h8000_0008;
    bus3.req_valid = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("l3_blk%0d", i), 64'(bus3.req_ready), 64'd0);
      if (i < 4) begin
        chk($sformatf("l3_ren%0d", i), 64'(ren3), 64'd1);
        chk($sformatf("l3_ridx%0d", i), ridx3, 64'd2);
        chk($sformatf("l3_norsp%0d", i),
            64'(bus3.rsp_valid), 64'd0);
      end else begin
        chk("l3_rsp", 64'(bus3.rsp_valid), 64'd1);
        chk("l3_rdata", bus3.rsp_rdata, 64'h5555_6666_7777_8888);
        chk("l3_ren_off", 64'(ren3), 64'd0);
      end
    end
    @(negedge clk);
    chk("l3_rdy1", 64'(bus3.req_ready), 64'd2);
    @(posedge clk); #1;
    bus3.req_valid = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus3.rsp_valid == 2'b00 && lat < 10);
    chk("l3_lat1", 64'(lat), 64'd4);
    chk("l3_rsp1", 64'(bus3.rsp_valid), 64'd2);
    chk("l3_rdata1", bus3.rsp_rdata, 64'h1234_5678_9ABC_DEF0);

    run3(0, 64'h8000_0010, 64'h5555_6666_7777_8888, "l3b");

    // reset while port1's read sits in WAIT
    @(posedge clk); #1;
    bus3.req_valid = 2'b10;
    @(negedge clk);
    chk("rw_rdy", 64'(bus3.req_ready), 64'd2);
    @(posedge clk); #1;
    bus3.req_valid = '0;
    @(posedge clk); #1;
    chk("rw_inwait", 64'(ren3), 64'd1);
    rst = 1'b0;
    #1 zero_chk("rmid");
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus3.rsp_valid != 2'b00) seen++;
    end
    chk("rw_norsp", 64'(seen), 64'd0);
    @(posedge clk); #1;
    bus3.req_valid = 2'b11;
    @(negedge clk);
    chk("rw_ptr0", 64'(bus3.req_ready), 64'd1);
    @(posedge clk); #1;
    bus3.req_valid = '0;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
